// File: rtl/sqi_mem_ctrl.sv
// SQI memory controller: word requests served over SQI_NUM lock-step quad-SPI memories, one nibble lane each.
// Build option SQI_STREAM_EN keeps chip-select asserted (HOLD) so sequential accesses skip command/address.
module sqi_mem_ctrl #(
  parameter int SQI_NUM = 2,
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_vld,
  output logic                 o_req_rdy,
  input  logic                 i_req_wr,
  input  logic [ADDR_W-1:0]    i_req_addr,
  input  logic [WORD_W-1:0]    i_req_data,
  output logic                 o_rsp_vld,
  output logic [WORD_W-1:0]    o_rsp_data,
  output logic                 o_sqi_cs_n,
  output logic                 o_sqi_sck_en,
  output logic [4*SQI_NUM-1:0] o_sqi_sio,
  output logic [SQI_NUM-1:0]   o_sqi_oe,
  input  logic [4*SQI_NUM-1:0] i_sqi_sio
);

  localparam int LANE_W  = 4 * SQI_NUM;
  localparam int BEATS   = WORD_W / LANE_W;
  localparam int BPW     = WORD_W / (8 * SQI_NUM);
  localparam int CNT_MAX = (BEATS > 6) ? BEATS : 6;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END
`ifdef SQI_STREAM_EN
    , S_HOLD
`endif
  } state_t;

  typedef struct packed {
    logic               rdy;
    logic               cs_n;
    logic               sck_en;
    logic [SQI_NUM-1:0] oe;
    logic [LANE_W-1:0]  sio;
  } pins_t;

  // Pin values for the cycle spent in state s at step c; called with the values the
  // registers are about to take, so every pin comes straight out of a flop.
  function automatic pins_t drive(state_t s, cnt_t c, logic wr,
                                  logic [ADDR_W-1:0] addr, logic [WORD_W-1:0] data);
    pins_t       p;
    logic [7:0]  cmd;
    logic [23:0] ash;
    logic [WORD_W-1:0] dsh;
    // NOTE: every field gets a default before the case, so no path can leave it unassigned.
    p.rdy    = 1'b0;
    p.cs_n   = 1'b0;
    p.sck_en = 1'b1;
    p.oe     = '0;
    p.sio    = '0;
    cmd      = wr ? 8'h02 : 8'h03;
    ash      = '0;
    dsh      = '0;
    case (s)
      S_IDLE: begin
        p.rdy    = 1'b1;
        p.cs_n   = 1'b1;
        p.sck_en = 1'b0;
      end
      S_CMD: begin
        p.oe  = '1;
        p.sio = {SQI_NUM{(c == '0) ? cmd[7:4] : cmd[3:0]}};
      end
      S_ADDR: begin
        ash   = (24'(addr) * 24'(BPW)) >> (4 * (5 - int'(c)));
        p.oe  = '1;
        p.sio = {SQI_NUM{ash[3:0]}};
      end
      S_DUMMY: p.oe = '0;
      S_DATA: begin
        if (wr) begin
          dsh   = data >> (LANE_W * int'(c));
          p.oe  = '1;
          p.sio = dsh[LANE_W-1:0];
        end
      end
`ifdef SQI_STREAM_EN
      S_HOLD: begin
        p.rdy    = 1'b1;
        p.sck_en = 1'b0;
      end
`endif
      default: begin
        p.cs_n   = 1'b1;
        p.sck_en = 1'b0;
      end
    endcase
    return p;
  endfunction

  state_t            state;
  cnt_t              cnt;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_data;
  logic [WORD_W-1:0] rd_sh;
  pins_t             pins;
  logic              rsp_vld;
  logic [WORD_W-1:0] rsp_data;

  cnt_t              cnt_inc;
  logic [WORD_W-1:0] rd_next;

  assign cnt_inc = cnt + 1'b1;
  // Beat 0 carries the least-significant slice, so shift in from the top.
  assign rd_next = {i_sqi_sio, rd_sh[WORD_W-1:LANE_W]};

`ifdef SQI_STREAM_EN
  logic pend;
  logic seq_hit;
  // A wrap to address 0 is deliberately not a sequential continuation.
  assign seq_hit = (i_req_wr == lat_wr) && (i_req_addr == ADDR_W'(lat_addr + 1'b1)) &&
                   (i_req_addr != '0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      rd_sh    <= '0;
      pins     <= drive(S_IDLE, '0, 1'b0, '0, '0);
      rsp_vld  <= 1'b0;
      rsp_data <= '0;
`ifdef SQI_STREAM_EN
      pend     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge register values.
      rsp_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req_vld) begin
            lat_wr   <= i_req_wr;
            lat_addr <= i_req_addr;
            lat_data <= i_req_data;
            state    <= S_CMD;
            cnt      <= '0;
            pins     <= drive(S_CMD, '0, i_req_wr, i_req_addr, i_req_data);
          end
        end
        S_CMD: begin
          if (cnt == cnt_t'(1)) begin
            state <= S_ADDR;
            cnt   <= '0;
            pins  <= drive(S_ADDR, '0, lat_wr, lat_addr, lat_data);
          end else begin
            cnt  <= cnt_inc;
            pins <= drive(S_CMD, cnt_inc, lat_wr, lat_addr, lat_data);
          end
        end
        S_ADDR: begin
          if (cnt == cnt_t'(5)) begin
            cnt <= '0;
            if (lat_wr) begin
              state <= S_DATA;
              pins  <= drive(S_DATA, '0, lat_wr, lat_addr, lat_data);
            end else begin
              state <= S_DUMMY;
              pins  <= drive(S_DUMMY, '0, lat_wr, lat_addr, lat_data);
            end
          end else begin
            cnt  <= cnt_inc;
            pins <= drive(S_ADDR, cnt_inc, lat_wr, lat_addr, lat_data);
          end
        end
        S_DUMMY: begin
          if (cnt == cnt_t'(1)) begin
            state <= S_DATA;
            cnt   <= '0;
            pins  <= drive(S_DATA, '0, lat_wr, lat_addr, lat_data);
          end else begin
            cnt  <= cnt_inc;
            pins <= drive(S_DUMMY, cnt_inc, lat_wr, lat_addr, lat_data);
          end
        end
        S_DATA: begin
          if (!lat_wr) rd_sh <= rd_next;
          if (cnt == cnt_t'(BEATS - 1)) begin
            cnt     <= '0;
            rsp_vld <= 1'b1;
            if (!lat_wr) rsp_data <= rd_next;
`ifdef SQI_STREAM_EN
            state   <= S_HOLD;
            pins    <= drive(S_HOLD, '0, lat_wr, lat_addr, lat_data);
`else
            state   <= S_END;
            pins    <= drive(S_END, '0, lat_wr, lat_addr, lat_data);
`endif
          end else begin
            cnt  <= cnt_inc;
            pins <= drive(S_DATA, cnt_inc, lat_wr, lat_addr, lat_data);
          end
        end
        S_END: begin
`ifdef SQI_STREAM_EN
          // Leaving HOLD for a non-sequential request: its response was already
          // pulsed in HOLD, and the new request is replayed from CMD.
          if (pend) begin
            pend  <= 1'b0;
            state <= S_CMD;
            cnt   <= '0;
            pins  <= drive(S_CMD, '0, lat_wr, lat_addr, lat_data);
          end else begin
            state <= S_IDLE;
            pins  <= drive(S_IDLE, '0, lat_wr, lat_addr, lat_data);
          end
`else
          state <= S_IDLE;
          pins  <= drive(S_IDLE, '0, lat_wr, lat_addr, lat_data);
`endif
        end
`ifdef SQI_STREAM_EN
        S_HOLD: begin
          if (i_req_vld) begin
            lat_wr   <= i_req_wr;
            lat_addr <= i_req_addr;
            lat_data <= i_req_data;
            cnt      <= '0;
            if (seq_hit) begin
              state <= S_DATA;
              pins  <= drive(S_DATA, '0, i_req_wr, i_req_addr, i_req_data);
            end else begin
              state <= S_END;
              pend  <= 1'b1;
              pins  <= drive(S_END, '0, i_req_wr, i_req_addr, i_req_data);
            end
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          pins  <= drive(S_IDLE, '0, lat_wr, lat_addr, lat_data);
        end
      endcase
    end
  end

  assign o_req_rdy    = pins.rdy;
  assign o_sqi_cs_n   = pins.cs_n;
  assign o_sqi_sck_en = pins.sck_en;
  assign o_sqi_oe     = pins.oe;
  assign o_sqi_sio    = pins.sio;
  assign o_rsp_vld    = rsp_vld;
  assign o_rsp_data   = rsp_data;

endmodule

// File: tb/tb_sqi_mem_ctrl.sv
// Bench for sqi_mem_ctrl: default 2x16-bit instance against a word-level memory model, plus a 4x32-bit instance.
// Compile with SQI_STREAM_EN defined to exercise the HOLD/streaming behaviour.
`timescale 1ns/1ps
module tb_sqi_mem_ctrl;

  localparam int BEATS = 2;
  localparam int BPW   = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_vld = 1'b0, req_wr = 1'b0;
  logic [15:0] req_addr = '0, req_data = '0;
  logic        req_rdy, rsp_vld, cs_n, sck_en;
  logic [15:0] rsp_data;
  logic [7:0]  sio_o;
  logic [7:0]  sio_in = '0;
  logic [1:0]  oe;

  logic        w_vld = 1'b0, w_wr = 1'b0;
  logic [15:0] w_addr = '0;
  logic [31:0] w_data = '0;
  logic        w_rdy, w_rsp_vld, w_cs_n, w_sck_en;
  logic [31:0] w_rsp_data;
  logic [15:0] w_sio_o;
  logic [15:0] w_sio_in = '0;
  logic [3:0]  w_oe;

  sqi_mem_ctrl #(.SQI_NUM(2), .WORD_W(16), .ADDR_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld), .o_req_rdy(req_rdy),
    .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_rsp_vld(rsp_vld), .o_rsp_data(rsp_data), .o_sqi_cs_n(cs_n),
    .o_sqi_sck_en(sck_en), .o_sqi_sio(sio_o), .o_sqi_oe(oe), .i_sqi_sio(sio_in)
  );

  sqi_mem_ctrl #(.SQI_NUM(4), .WORD_W(32), .ADDR_W(16)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(w_vld), .o_req_rdy(w_rdy),
    .i_req_wr(w_wr), .i_req_addr(w_addr), .i_req_data(w_data),
    .o_rsp_vld(w_rsp_vld), .o_rsp_data(w_rsp_data), .o_sqi_cs_n(w_cs_n),
    .o_sqi_sck_en(w_sck_en), .o_sqi_sio(w_sio_o), .o_sqi_oe(w_oe), .i_sqi_sio(w_sio_in)
  );

  int tests = 0;
  int fails = 0;

  // Word-level model of the memory array plus the controller's streaming context.
  logic [15:0] mem [int];
  logic        in_hold   = 1'b0;
  logic        last_wr   = 1'b0;
  logic [15:0] last_addr = '0;

  typedef struct {
    logic       cs_n;
    logic       sck;
    logic [1:0] oe;
    logic [7:0] sio;
    logic       vld;
    logic       rdy;
    int         beat;
  } cyc_t;

  function automatic cyc_t mk(logic c, logic s, logic [1:0] o, logic [7:0] d,
                              logic v, logic r, int b);
    cyc_t x;
    x.cs_n = c; x.sck = s; x.oe = o; x.sio = d; x.vld = v; x.rdy = r; x.beat = b;
    return x;
  endfunction

  function automatic logic [15:0] mem_rd(int a);
    if (mem.exists(a)) return mem[a];
    return 16'(a * 40503 + 17);
  endfunction

  // One transaction on the default instance, checked cycle by cycle against the expected pin sequence.
  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                        input string name);
    cyc_t        q[$];
    int          mode;
    int          n;
    logic [7:0]  cmd;
    logic [23:0] ba;
    logic [15:0] exp_rd;
    logic [15:0] wr_col;
    bit          bad;
    string       why;
    mode = 0;
`ifdef SQI_STREAM_EN
    if (in_hold) mode = (wr == last_wr && addr == 16'(last_addr + 16'd1) && addr != 16'd0) ? 1 : 2;
`endif
    if (mode == 2) q.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, -1));
    if (mode != 1) begin
      cmd = wr ? 8'h02 : 8'h03;
      q.push_back(mk(1'b0, 1'b1, 2'b11, {2{cmd[7:4]}}, 1'b0, 1'b0, -1));
      q.push_back(mk(1'b0, 1'b1, 2'b11, {2{cmd[3:0]}}, 1'b0, 1'b0, -1));
      ba = 24'(addr) * 24'(BPW);
      for (int j = 0; j < 6; j++) begin
        logic [23:0] t;
        t = ba >> (20 - 4 * j);
        q.push_back(mk(1'b0, 1'b1, 2'b11, {2{t[3:0]}}, 1'b0, 1'b0, -1));
      end
      if (!wr) repeat (2) q.push_back(mk(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, -1));
    end
    for (int k = 0; k < BEATS; k++)
      q.push_back(mk(1'b0, 1'b1, wr ? 2'b11 : 2'b00, wr ? 8'(data >> (8 * k)) : 8'h00,
                     1'b0, 1'b0, k));
`ifdef SQI_STREAM_EN
    q.push_back(mk(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1, -1));
`else
    q.push_back(mk(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0, -1));
`endif

    n = 0;
    @(negedge clk);
    while (!req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (req_rdy !== 1'b1 || (!in_hold && cs_n !== 1'b1)) begin
      fails++;
      $display("FAIL %s accept: req_rdy=%b cs_n=%b after %0d cycles, required req_rdy=1 (cs_n=1 when idle)",
               name, req_rdy, cs_n, n);
      return;
    end
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_data = data;
    @(posedge clk);
    #1 req_vld = 1'b0;

    exp_rd = mem_rd(int'(addr));
    wr_col = '0;
    bad    = 1'b0;
    why    = "";
    foreach (q[c]) begin
      @(negedge clk);
      sio_in = (!wr && q[c].beat >= 0) ? 8'(exp_rd >> (8 * q[c].beat)) : 8'h00;
      if (wr && q[c].beat >= 0) wr_col |= 16'(sio_o) << (8 * q[c].beat);
      if (!bad && (cs_n !== q[c].cs_n || sck_en !== q[c].sck || oe !== q[c].oe ||
                   rsp_vld !== q[c].vld || req_rdy !== q[c].rdy ||
                   (q[c].oe != 2'b00 && sio_o !== q[c].sio))) begin
        bad = 1'b1;
        why = $sformatf("T+%0d got cs_n=%b sck_en=%b oe=%b sio=%h vld=%b rdy=%b, required cs_n=%b sck_en=%b oe=%b sio=%h vld=%b rdy=%b",
                        c + 1, cs_n, sck_en, oe, sio_o, rsp_vld, req_rdy,
                        q[c].cs_n, q[c].sck, q[c].oe, q[c].sio, q[c].vld, q[c].rdy);
      end
    end
    sio_in = '0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL %s pins: %s", name, why);
    end
    tests++;
    if (!wr) begin
      if (rsp_data !== exp_rd) begin
        fails++;
        $display("FAIL %s rsp_data: got %h, required %h", name, rsp_data, exp_rd);
      end
    end else begin
      if (wr_col !== data) begin
        fails++;
        $display("FAIL %s write lanes: memory saw %h, required %h", name, wr_col, data);
      end
      mem[int'(addr)] = data;
    end
    last_wr   = wr;
    last_addr = addr;
`ifdef SQI_STREAM_EN
    in_hold = 1'b1;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({cs_n, sck_en, oe, sio_o, rsp_vld, rsp_data, req_rdy} !== {1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 16'h0000, 1'b1}) begin
      fails++;
      $display("FAIL reset_x2: got cs_n=%b sck_en=%b oe=%b sio=%h vld=%b data=%h rdy=%b, required 1 0 00 00 0 0000 1",
               cs_n, sck_en, oe, sio_o, rsp_vld, rsp_data, req_rdy);
    end
    tests++;
    if ({w_cs_n, w_sck_en, w_oe, w_sio_o, w_rsp_vld, w_rsp_data, w_rdy} !== {1'b1, 1'b0, 4'h0, 16'h0, 1'b0, 32'h0, 1'b1}) begin
      fails++;
      $display("FAIL reset_x4: got cs_n=%b sck_en=%b oe=%b sio=%h vld=%b data=%h rdy=%b, required 1 0 0 0000 0 0 1",
               w_cs_n, w_sck_en, w_oe, w_sio_o, w_rsp_vld, w_rsp_data, w_rdy);
    end
    in_hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 16'h0055;
    @(posedge clk);
    #1 req_vld = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (cs_n !== 1'b0 || oe !== 2'b11) begin
      fails++;
      $display("FAIL reset_mid in_addr: got cs_n=%b oe=%b, required 0 11", cs_n, oe);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cs_n, sck_en, oe, req_rdy, rsp_vld} !== 6'b1_0_00_1_0) begin
      fails++;
      $display("FAIL reset_mid immediate: got cs_n=%b sck_en=%b oe=%b rdy=%b vld=%b, required 1 0 00 1 0",
               cs_n, sck_en, oe, req_rdy, rsp_vld);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    in_hold = 1'b0;
    seen    = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_vld === 1'b1 || cs_n !== 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL reset_mid dropped: got activity or response after release, required none");
    end
  endtask

  task automatic test_read_basic();
    mem[16'h0012] = 16'h1234;
    do_txn(1'b0, 16'h0012, 16'h0000, "read_0012");
  endtask

  task automatic test_write_basic();
    do_txn(1'b1, 16'h0001, 16'hBEEF, "write_0001");
    do_txn(1'b0, 16'h0001, 16'h0000, "readback_0001");
  endtask

  task automatic test_wide_read();
    logic        ecs, esck, evld;
    logic [3:0]  eoe;
    logic [15:0] esio;
    bit          bad;
    string       why;
    @(negedge clk);
    w_vld = 1'b1; w_wr = 1'b0; w_addr = 16'h0003;
    @(posedge clk);
    #1 w_vld = 1'b0;
    bad = 1'b0;
    why = "";
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      w_sio_in = (c == 11) ? 16'h3210 : (c == 12) ? 16'h7654 : 16'h0000;
      ecs = 1'b0; esck = 1'b1; evld = 1'b0; eoe = 4'h0; esio = 16'h0000;
      if (c == 1)               begin eoe = 4'hF; esio = 16'h0000; end
      else if (c == 2)          begin eoe = 4'hF; esio = 16'h3333; end
      else if (c <= 8)          begin eoe = 4'hF; esio = (c == 8) ? 16'h3333 : 16'h0000; end
      else if (c == 13) begin
        evld = 1'b1; esck = 1'b0;
`ifndef SQI_STREAM_EN
        ecs = 1'b1;
`endif
      end
      if (!bad && (w_cs_n !== ecs || w_sck_en !== esck || w_oe !== eoe || w_rsp_vld !== evld ||
                   (eoe != 4'h0 && w_sio_o !== esio))) begin
        bad = 1'b1;
        why = $sformatf("T+%0d got cs_n=%b sck_en=%b oe=%h sio=%h vld=%b, required %b %b %h %h %b",
                        c, w_cs_n, w_sck_en, w_oe, w_sio_o, w_rsp_vld, ecs, esck, eoe, esio, evld);
      end
    end
    w_sio_in = '0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL wide_read pins: %s", why);
    end
    tests++;
    if (w_rsp_data !== 32'h76543210) begin
      fails++;
      $display("FAIL wide_read rsp_data: got %h, required 76543210", w_rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 16'h0040, 16'h5A5A, "b2b_write");
    do_txn(1'b0, 16'h0040, 16'h0000, "b2b_read");
    do_txn(1'b0, 16'h0041, 16'h0000, "b2b_read_next");
  endtask

  task automatic test_random();
    logic        wr;
    logic [15:0] addr;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
`ifdef SQI_STREAM_EN
      if ($urandom_range(0, 1) == 1) begin
        wr   = last_wr;
        addr = 16'(last_addr + 16'd1);
      end else
        addr = 16'($urandom_range(0, 63));
`else
      addr = 16'($urandom_range(0, 63));
`endif
      do_txn(wr, addr, 16'($urandom), $sformatf("random_%0d", i));
    end
  endtask

`ifdef SQI_STREAM_EN
  task automatic test_stream();
    do_txn(1'b0, 16'h0010, 16'h0000, "stream_0010");
    do_txn(1'b0, 16'h0011, 16'h0000, "stream_0011_seq");
    do_txn(1'b0, 16'h0020, 16'h0000, "stream_0020_jump");
    do_txn(1'b1, 16'h0021, 16'hC0DE, "stream_dir_change");
  endtask

  task automatic test_wrap();
    do_txn(1'b0, 16'hFFFF, 16'h0000, "wrap_ffff");
    do_txn(1'b0, 16'h0000, 16'h0000, "wrap_0000");
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_read_basic();
    test_write_basic();
    test_wide_read();
    test_back_to_back();
`ifdef SQI_STREAM_EN
    test_stream();
    test_wrap();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
